mem_arbiter: RTL

Two-port line-memory arbiter that lets the instruction cache and the data cache share one slow 128-bit line memory. It sits between the two `cache` instances and the single off-chip memory interface. It serialises whole line transactions, one read or one write each, and captures each granted request into holding registers. Memory-side signals therefore stay stable even if a requester changes its request mid-transaction.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_pick.sv | 29 ++
 rtl/mem_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port line-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: I-cache port, D-cache port and the shared memory port.
// slave = arbiter view, master = caches plus memory.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
);
    logic              mem_read_I;
    logic              mem_write_I;
    logic [ADDR_W-1:0] mem_addr_I;
    logic [LINE_W-1:0] mem_wdata_I;
    logic [LINE_W-1:0] mem_rdata_I;
    logic              mem_ready_I;

    logic              mem_read_D;
    logic              mem_write_D;
    logic [ADDR_W-1:0] mem_addr_D;
    logic [LINE_W-1:0] mem_wdata_D;
    logic [LINE_W-1:0] mem_rdata_D;
    logic              mem_ready_D;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
        output mem_rdata_I, mem_ready_I,
        input  mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
        output mem_rdata_D, mem_ready_D,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
        input  mem_rdata_I, mem_ready_I,
        output mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
        input  mem_rdata_D, mem_ready_D,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between the I and D requesters.
// MEM_ARB_RR_EN: ties go to the port not granted last; otherwise D always wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req_I,
    input  logic req_D,
`ifdef MEM_ARB_RR_EN
    input  logic last_owner,
`endif
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = req_I | req_D;
        grant_owner = OWN_I;
        if (req_I && req_D) begin
`ifdef MEM_ARB_RR_EN
            grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
`else
            grant_owner = OWN_D;
`endif
        end else if (req_D) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache line transactions onto one line memory.
// Optional MEM_ARB_RR_EN selects round-robin tie breaking in the picker.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus,
    output logic          arb_busy,
    output logic          arb_owner
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_BUSY_I = BUSY_I;
    localparam logic [1:0] ST_BUSY_D = BUSY_D;

    logic [1:0]        state_reg, state_next;
    logic              hold_read_reg, hold_write_reg;
    logic [ADDR_W-1:0] hold_addr_reg;
    logic [LINE_W-1:0] hold_wdata_reg;
    logic              owner_reg;

    logic req_i, req_d, grant_valid, grant_owner;
    logic              sel_read, sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;

    assign req_i = bus.mem_read_I | bus.mem_write_I;
    assign req_d = bus.mem_read_D | bus.mem_write_D;

    // The owner register doubles as the last-grant record for round-robin.
    mem_arb_pick u_pick (
        .req_I       (req_i),
        .req_D       (req_d),
`ifdef MEM_ARB_RR_EN
        .last_owner  (owner_reg),
`endif
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Write takes precedence when a requester raises both read and write.
    always_comb begin
        sel_write = (grant_owner == OWN_D) ? bus.mem_write_D : bus.mem_write_I;
        sel_read  = ((grant_owner == OWN_D) ? bus.mem_read_D : bus.mem_read_I) & ~sel_write;
        sel_addr  = (grant_owner == OWN_D) ? bus.mem_addr_D  : bus.mem_addr_I;
        sel_wdata = (grant_owner == OWN_D) ? bus.mem_wdata_D : bus.mem_wdata_I;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_valid)
                    state_next = (grant_owner == OWN_D) ? ST_BUSY_D : ST_BUSY_I;
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (bus.mem_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            hold_read_reg  <= 1'b0;
            hold_write_reg <= 1'b0;
            hold_addr_reg  <= '0;
            hold_wdata_reg <= '0;
            owner_reg      <= OWN_I;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && grant_valid) begin
                hold_read_reg  <= sel_read;
                hold_write_reg <= sel_write;
                hold_addr_reg  <= sel_addr;
                hold_wdata_reg <= sel_wdata;
                owner_reg      <= grant_owner;
            end
        end
    end

    assign arb_busy  = (state_reg != ST_IDLE);
    assign arb_owner = owner_reg;

    // Memory side sees only the holding registers, so requester changes are invisible.
    assign bus.mem_read  = arb_busy & hold_read_reg;
    assign bus.mem_write = arb_busy & hold_write_reg;
    assign bus.mem_addr  = hold_addr_reg;
    assign bus.mem_wdata = hold_wdata_reg;

    assign bus.mem_ready_I = (state_reg == ST_BUSY_I) & bus.mem_ready;
    assign bus.mem_ready_D = (state_reg == ST_BUSY_D) & bus.mem_ready;
    assign bus.mem_rdata_I = bus.mem_rdata;
    assign bus.mem_rdata_D = bus.mem_rdata;

endmodule
